// File: rtl/tdm_pkg.sv
// Shared constants for the 4-channel TDM demultiplexer: channel count,
// channel-index width and FSM state encoding.
package tdm_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/tdm_demux14_if.sv
// Sample-stream and per-channel output bundle of the TDM demultiplexer.
interface tdm_demux14_if
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] dout0;
    logic [WIDTH-1:0] dout1;
    logic [WIDTH-1:0] dout2;
    logic [WIDTH-1:0] dout3;
    logic             vld0;
    logic             vld1;
    logic             vld2;
    logic             vld3;
    logic             frame_done;
    logic             frame_err;
    logic [CH_W-1:0]  ch_sel;

    modport master (
        output din, din_valid, frame_sync,
        input  dout0, dout1, dout2, dout3,
        input  vld0, vld1, vld2, vld3,
        input  frame_done, frame_err, ch_sel
    );

    modport slave (
        input  din, din_valid, frame_sync,
        output dout0, dout1, dout2, dout3,
        output vld0, vld1, vld2, vld3,
        output frame_done, frame_err, ch_sel
    );

endinterface

// File: rtl/dec24.sv
// 2-to-4 one-hot decoder with enable; produces per-channel write enables.
module dec24
    import tdm_pkg::*;
(
    input  logic              en,
    input  logic [CH_W-1:0]   sel,
    output logic [NUM_CH-1:0] dec_c
);

    always_comb begin
        dec_c = '0;
        if (en) dec_c[sel] = 1'b1;
    end

endmodule

// File: rtl/tdm_demux14.sv
// Four-channel TDM demultiplexer: routes a framed sample stream into per-channel
// holding registers with registered strobes, frame-done and protocol-error pulses.
module tdm_demux14
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux14_if.slave  bus
);

    logic [0:0]        state;
    logic [0:0]        state_nx;
    logic [CH_W-1:0]   ch_cnt;
    logic [CH_W-1:0]   cnt_nx;
    logic              done_nx;
    logic              err_nx;
    logic              rst_ok;
    logic              acc_sync;
    logic              acc_run;
    logic [CH_W-1:0]   wr_idx;
    logic [NUM_CH-1:0] we_c;
    logic [NUM_CH-1:0] vld_q;
    logic              done_q;
    logic              err_q;
    logic [WIDTH-1:0]  dout_q [NUM_CH];

    // Reset release is retimed so the first sample is taken at the second edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_ok <= 1'b0;
        else        rst_ok <= 1'b1;
    end

    assign acc_sync = rst_ok & bus.din_valid & bus.frame_sync;
    assign acc_run  = rst_ok & bus.din_valid & ~bus.frame_sync & (state == ST_RUN);
    assign wr_idx   = acc_sync ? CH_W'(0) : ch_cnt;

    dec24 u_dec24 (
        .en    (acc_sync | acc_run),
        .sel   (wr_idx),
        .dec_c (we_c)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = ch_cnt;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        if (acc_sync) begin
            err_nx   = (state == ST_RUN) && (ch_cnt != CH_W'(0));
            cnt_nx   = CH_W'(1);
            state_nx = ST_RUN;
        end else if (acc_run) begin
            if (ch_cnt == CH_W'(NUM_CH - 1)) begin
                done_nx  = 1'b1;
                cnt_nx   = CH_W'(0);
                state_nx = ST_IDLE;
            end else begin
                cnt_nx = ch_cnt + CH_W'(1);
            end
        end else if (rst_ok && bus.din_valid && state == ST_IDLE) begin
            err_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ch_cnt <= '0;
            vld_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_nx;
            ch_cnt <= cnt_nx;
            vld_q  <= we_c;
            done_q <= done_nx;
            err_q  <= err_nx;
        end
    end

    // One holding register per channel, loaded only on its decoded enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(NUM_CH); k++) dout_q[k] <= '0;
        end else begin
            for (int k = 0; k < int'(NUM_CH); k++)
                if (we_c[k]) dout_q[k] <= bus.din;
        end
    end

    assign bus.dout0      = dout_q[0];
    assign bus.dout1      = dout_q[1];
    assign bus.dout2      = dout_q[2];
    assign bus.dout3      = dout_q[3];
    assign bus.vld0       = vld_q[0];
    assign bus.vld1       = vld_q[1];
    assign bus.vld2       = vld_q[2];
    assign bus.vld3       = vld_q[3];
    assign bus.frame_done = done_q;
    assign bus.frame_err  = err_q;
    assign bus.ch_sel     = ch_cnt;

endmodule
